mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `recurse_mux` datapath among `2**S` requesters of `T`-bit data. It registers the winning index and drives it as the mux select (`ctrl`), exposes the selected word on a valid/ready output port, and pulses a per-requester acknowledge on each accepted word. A grant is held for a burst of up to `B` words, then the winner rotates. The block sits between a bank of producers and the single downstream consumer that previously drove `recurse_mux` select lines directly.

---
 rtl/mux_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin burst arbiter in front of a shared recurse_mux datapath
//
// recurse_mux : 2**S to 1 mux of T-bit words, built as a binary tree.
//   sel  in  S        select index
//   in   in  T*2**S   packed words, word i at [i*T +: T]
//   out  out T        selected word
//
// mux_rr_arbiter : grants one of N = 2**S requesters for up to B words, then rotates.
//   clk        in  1    clock
//   rst_n      in  1    synchronous active-low reset
//   req        in  N    per-requester request level
//   in         in  N*T  packed requester data
//   out_ready  in  1    downstream accepts out_data
//   grant      out N    one-hot registered grant, zero when idle
//   ctrl       out S    registered winner index, drives the mux select
//   out_valid  out 1    out_data is valid
//   out_data   out T    word of requester ctrl
//   ack        out N    one-hot pulse when requester ctrl's word is consumed

module recurse_mux #(
  parameter int S = 2,
  parameter int T = 8
) (
  input  logic [S-1:0]      sel,
  input  logic [(T<<S)-1:0] in,
  output logic [T-1:0]      out
);

  generate
    if (S == 1) begin : g_leaf
      assign out = sel[0] ? in[2*T-1:T] : in[T-1:0];
    end else begin : g_split
      // Lower half of the words goes to one subtree, upper half to the other;
      // the top select bit picks between them.
      localparam int H = T << (S - 1);
      logic [T-1:0] lo;
      logic [T-1:0] hi;

      recurse_mux #(.S(S - 1), .T(T)) u_lo (
        .sel (sel[S-2:0]),
        .in  (in[H-1:0]),
        .out (lo)
      );

      recurse_mux #(.S(S - 1), .T(T)) u_hi (
        .sel (sel[S-2:0]),
        .in  (in[2*H-1:H]),
        .out (hi)
      );

      assign out = sel[S-1] ? hi : lo;
    end
  endgenerate

endmodule

module mux_rr_arbiter #(
  parameter int S = 2,
  parameter int T = 8,
  parameter int B = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [(1<<S)-1:0]    req,
  input  logic [(T<<S)-1:0]    in,
  input  logic                 out_ready,
  output logic [(1<<S)-1:0]    grant,
  output logic [S-1:0]         ctrl,
  output logic                 out_valid,
  output logic [T-1:0]         out_data,
  output logic [(1<<S)-1:0]    ack
);

  localparam int N  = 1 << S;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(B - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [S-1:0]  ptr;
  logic [CW-1:0] cnt;
  logic [S-1:0]  winner;
  logic          found;
  logic          xfer;
  logic          release_c;

  // First requester at or after ptr, scanning upward with wrap. The S-bit
  // addition wraps modulo N on its own.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[ptr + S'(k)]) begin
        winner = ptr + S'(k);
        found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (release_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. A granted requester that drops req releases the grant at the
  // next edge; a full burst releases on its last transfer.
  always_comb begin
    out_valid = (state == BUSY) && req[ctrl];
    xfer      = out_valid && out_ready;
    ack       = '0;
    if (xfer) begin
      ack[ctrl] = 1'b1;
    end
    release_c = (state == BUSY) && (!req[ctrl] || (xfer && (cnt == CNT_LAST)));
  end

  // Grant, select, rotation pointer and burst counter. ctrl is left alone on
  // release so the mux output stays stable through the idle bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl  <= '0;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ctrl  <= winner;
            grant <= ONE_HOT0 << winner;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (release_c) begin
            grant <= '0;
            ptr   <= ctrl + S'(1);
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

  recurse_mux #(.S(S), .T(T)) u_mux (
    .sel (ctrl),
    .in  (in),
    .out (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter

module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_bus;
  logic        out_ready;
  logic [3:0]  grant;
  logic [1:0]  ctrl;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  ack;

  logic        rst1_n;
  logic [3:0]  req1;
  logic        rdy1;
  logic [3:0]  grant1;
  logic [1:0]  ctrl1;
  logic        valid1;
  logic [7:0]  data1;
  logic [3:0]  ack1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.S(2), .T(8), .B(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in_bus),
    .out_ready (out_ready),
    .grant     (grant),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack)
  );

  mux_rr_arbiter #(.S(2), .T(8), .B(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .req       (req1),
    .in        (in_bus),
    .out_ready (rdy1),
    .grant     (grant1),
    .ctrl      (ctrl1),
    .out_valid (valid1),
    .out_data  (data1),
    .ack       (ack1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input int idx);
    chk({tag, " grant"}, grant, 32'(1 << idx));
    chk({tag, " ctrl"}, ctrl, 32'(idx));
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " data"}, out_data, 32'(8'h10 + idx));
    chk({tag, " ack"}, ack, 32'(1 << idx));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, grant, 0);
    chk({tag, " valid"}, out_valid, 0);
    chk({tag, " ack"}, ack, 0);
  endtask

  initial begin
    in_bus    = 32'h1312_1110;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    rst1_n    = 1'b0;
    req1      = 4'b0000;
    rdy1      = 1'b1;

    // Reset held two cycles with all requests active.
    for (int r = 0; r < 2; r++) begin
      tick; settle;
      chk_idle("reset");
      chk("reset ctrl", ctrl, 0);
      chk("reset data", out_data, 8'h10);
    end
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    // Fair rotation: grants 0,1,2,3,0, four words each, one bubble after each.
    for (int g = 0; g < 5; g++) begin
      for (int w = 0; w < 4; w++) begin
        tick; settle;
        chk_busy("rotate", g % 4);
      end
      tick; settle;
      chk_idle("rotate bubble");
    end
    req = 4'b0000;

    // Early release on requester 2 after two transfers.
    tick; settle;
    chk_idle("early idle");
    req = 4'b0100;
    tick; settle;
    chk_busy("early w0", 2);
    tick; settle;
    chk_busy("early w1", 2);
    tick; settle;
    req = 4'b0000;
    settle;
    chk("early drop valid", out_valid, 0);
    chk("early drop ack", ack, 0);
    chk("early drop grant", grant, 4'b0100);
    tick; settle;
    chk_idle("early release");
    chk("early ptr", dut.ptr, 3);
    chk("early ctrl kept", ctrl, 2);
    req = 4'b0101;
    tick; settle;
    chk_busy("wrap to 0", 0);

    // Leave requester 0, then backpressure on requester 1.
    req = 4'b0000;
    settle;
    chk("rel0 valid", out_valid, 0);
    tick; settle;
    chk_idle("bp idle");
    req       = 4'b0010;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick; settle;
      chk("bp grant", grant, 4'b0010);
      chk("bp valid", out_valid, 1);
      chk("bp data", out_data, 8'h11);
      chk("bp ack", ack, 0);
      chk("bp cnt", dut.cnt, 0);
    end
    out_ready = 1'b1;
    settle;
    chk_busy("bp w0", 1);
    for (int w = 1; w < 4; w++) begin
      tick; settle;
      chk_busy("bp w", 1);
    end
    tick; settle;
    chk_idle("bp release");
    chk("bp ptr", dut.ptr, 2);

    // Reset in the middle of a burst on requester 2.
    req = 4'b0100;
    tick; settle;
    chk_busy("mid w0", 2);
    tick; settle;
    chk_busy("mid w1", 2);
    tick; settle;
    rst_n = 1'b0;
    tick; settle;
    chk_idle("mid reset");
    chk("mid reset ctrl", ctrl, 0);
    chk("mid reset cnt", dut.cnt, 0);
    rst_n = 1'b1;
    for (int w = 0; w < 4; w++) begin
      tick; settle;
      chk_busy("post reset", 2);
    end
    tick; settle;
    chk_idle("post reset bubble");
    req = 4'b0000;

    // B=1: grant 3, one word, idle, grant 0, then wrap back to 3.
    req1 = 4'b1000;
    tick; settle;
    chk("b1 grant3", grant1, 4'b1000);
    chk("b1 ctrl3", ctrl1, 3);
    chk("b1 data3", data1, 8'h13);
    chk("b1 ack3", ack1, 4'b1000);
    chk("b1 ptr a", dut1.ptr, 0);
    req1 = 4'b1001;
    tick; settle;
    chk("b1 idle grant", grant1, 0);
    chk("b1 idle valid", valid1, 0);
    chk("b1 ptr b", dut1.ptr, 0);
    tick; settle;
    chk("b1 grant0", grant1, 4'b0001);
    chk("b1 ctrl0", ctrl1, 0);
    chk("b1 data0", data1, 8'h10);
    chk("b1 ack0", ack1, 4'b0001);
    tick; settle;
    chk("b1 idle2 valid", valid1, 0);
    chk("b1 ptr c", dut1.ptr, 1);
    tick; settle;
    chk("b1 regrant3", grant1, 4'b1000);
    req1 = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
